t03_mem_sequencer: RTL and testbench

- Multi-cycle sequencer that shares the single external memory bus between instruction fetch and load/store data access.
- Drives the PC freeze so the PC advances exactly once per completed instruction.
- Sits between the PC/fetch path, the load/store unit and the bus master port.
- Issues one fetch per instruction, then an optional data access, then a one-cycle commit.

---
 rtl/t03_pkg.sv | 18 +
 rtl/t03_ack_timer.sv | 51 +++++
 rtl/t03_mem_sequencer.sv | 147 ++++++++++++++
 tb/tb_t03_mem_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/t03_pkg.sv
// t03_pkg: shared types and constants for the t03 memory sequencer.
//   mem_seq_state_t : sequencer FSM state encoding
//   T03_NOP         : instruction presented when no valid fetch exists (addi x0,x0,0)
//   T03_SEL_WORD    : full-word byte enables used for instruction fetch
package t03_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4
  } mem_seq_state_t;

  localparam logic [31:0] T03_NOP      = 32'h0000_0013;
  localparam logic [3:0]  T03_SEL_WORD = 4'hF;

endpackage

// File: rtl/t03_ack_timer.sv
// t03_ack_timer: bus acknowledge watchdog.
//   clk, rst : system clock, synchronous active-high reset
//   start    : pulse in the cycle before a request goes out; clears and arms the timer
//   ack      : accepted bus acknowledge
//   timeout  : high in the last allowed request cycle when no ack is present
// ACK_TIMEOUT = 0 disables the timeout output entirely.
module t03_ack_timer #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic ack,
  output logic timeout
);

  // Counter only has to reach ACK_TIMEOUT-1.
  localparam int W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

  logic [W-1:0] timer;
  logic         running;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      running <= 1'b0;
    end else if (start) begin
      timer   <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (ack || timeout) begin
        running <= 1'b0;
      end else begin
        timer <= timer + W'(1);
      end
    end
  end

  generate
    if (ACK_TIMEOUT == 0) begin : g_no_timeout
      assign timeout = 1'b0;
    end else begin : g_timeout
      localparam logic [W-1:0] LIMIT = W'(ACK_TIMEOUT - 1);
      // An ack in the final cycle wins over the timeout.
      assign timeout = running && !ack && (timer == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/t03_mem_sequencer.sv
// t03_mem_sequencer: shares one memory bus between instruction fetch and
// load/store access; one fetch, optional data access, one-cycle commit.
//   clk, rst            : system clock, synchronous active-high reset
//   i_fetch_addr        : PC memory address, latched when a fetch starts
//   i_data_read/write   : load/store request, sampled in S_EXEC (write wins)
//   i_data_addr/wdata/sel : load/store fields, latched at the end of S_EXEC
//   o_instr, o_instr_valid: latched instruction and its valid flag
//   o_data_rdata        : latched load data
//   o_freeze, o_commit  : PC freeze (low only in S_COMMIT), retire pulse
//   o_bus_err           : sticky ack-timeout flag
//   o_bus_*, i_bus_*    : bus master port; ack is a one-cycle strobe with rdata
module t03_mem_sequencer
  import t03_pkg::*;
#(
  parameter int          ACK_TIMEOUT = 255,
  parameter logic [31:0] NOP_INSTR   = T03_NOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_fetch_addr,
  input  logic        i_data_read,
  input  logic        i_data_write,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic [3:0]  i_data_sel,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_data_rdata,
  output logic        o_freeze,
  output logic        o_commit,
  output logic        o_bus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_sel,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  mem_seq_state_t state;
  logic           ack_ok;
  logic           req_start;
  logic           timeout;

  // Acks outside an open request are stray and ignored.
  assign ack_ok = i_bus_ack && o_bus_req;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_start = 1'b0;
    case (state)
      S_IDLE, S_COMMIT: req_start = 1'b1;
      S_EXEC:           req_start = i_data_read || i_data_write;
      default:          req_start = 1'b0;
    endcase
  end

  t03_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (req_start),
    .ack    (ack_ok),
    .timeout(timeout)
  );

  // All outputs are registered; o_freeze and o_commit are set on the edge
  // entering S_COMMIT so they are high for exactly that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      o_freeze      <= 1'b1;
      o_commit      <= 1'b0;
      o_bus_req     <= 1'b0;
      o_bus_we      <= 1'b0;
      o_bus_addr    <= '0;
      o_bus_wdata   <= '0;
      o_bus_sel     <= '0;
      o_instr       <= NOP_INSTR;
      o_instr_valid <= 1'b0;
      o_data_rdata  <= '0;
      o_bus_err     <= 1'b0;
    end else begin
      o_freeze <= 1'b1;
      o_commit <= 1'b0;
      case (state)
        S_IDLE, S_COMMIT: begin
          state         <= S_FETCH;
          o_bus_req     <= 1'b1;
          o_bus_we      <= 1'b0;
          o_bus_sel     <= T03_SEL_WORD;
          o_bus_addr    <= i_fetch_addr;
          o_instr_valid <= 1'b0;
        end
        S_FETCH: begin
          if (ack_ok) begin
            state         <= S_EXEC;
            o_bus_req     <= 1'b0;
            o_instr       <= i_bus_rdata;
            o_instr_valid <= 1'b1;
          end else if (timeout) begin
            state     <= S_EXEC;
            o_bus_req <= 1'b0;
            o_instr   <= NOP_INSTR;
            o_bus_err <= 1'b1;
          end
        end
        S_EXEC: begin
          o_bus_addr  <= i_data_addr;
          o_bus_wdata <= i_data_wdata;
          o_bus_sel   <= i_data_sel;
          if (i_data_write || i_data_read) begin
            state     <= S_DATA;
            o_bus_req <= 1'b1;
            o_bus_we  <= i_data_write;
          end else begin
            state    <= S_COMMIT;
            o_freeze <= 1'b0;
            o_commit <= 1'b1;
          end
        end
        S_DATA: begin
          if (ack_ok || timeout) begin
            state     <= S_COMMIT;
            o_bus_req <= 1'b0;
            o_freeze  <= 1'b0;
            o_commit  <= 1'b1;
            if (ack_ok) begin
              if (!o_bus_we) o_data_rdata <= i_bus_rdata;
            end else begin
              o_data_rdata <= '0;
              o_bus_err    <= 1'b1;
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          o_bus_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t03_mem_sequencer.sv
// tb_t03_mem_sequencer: directed self-checking bench for t03_mem_sequencer.
// Inputs are driven and outputs inspected 1 ns after each rising edge.
module tb_t03_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_fetch_addr = 32'h100;
  logic        i_data_read = 1'b0;
  logic        i_data_write = 1'b0;
  logic [31:0] i_data_addr = '0;
  logic [31:0] i_data_wdata = '0;
  logic [3:0]  i_data_sel = '0;
  logic [31:0] o_instr;
  logic        o_instr_valid;
  logic [31:0] o_data_rdata;
  logic        o_freeze;
  logic        o_commit;
  logic        o_bus_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_sel;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_bus_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  t03_mem_sequencer #(
    .ACK_TIMEOUT(4),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_fetch_addr (i_fetch_addr),
    .i_data_read  (i_data_read),
    .i_data_write (i_data_write),
    .i_data_addr  (i_data_addr),
    .i_data_wdata (i_data_wdata),
    .i_data_sel   (i_data_sel),
    .o_instr      (o_instr),
    .o_instr_valid(o_instr_valid),
    .o_data_rdata (o_data_rdata),
    .o_freeze     (o_freeze),
    .o_commit     (o_commit),
    .o_bus_err    (o_bus_err),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_sel    (o_bus_sel),
    .i_bus_ack    (i_bus_ack),
    .i_bus_rdata  (i_bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Serves one bus request already open: req held for lat cycles, ack in the last.
  task automatic bus_xfer(input string tag, input int lat, input logic [31:0] rdata,
                          input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input bit chk_wd);
    for (int i = 0; i < lat; i++) begin
      check({tag, "_req"},  32'(o_bus_req), 32'd1);
      check({tag, "_we"},   32'(o_bus_we), 32'(we));
      check({tag, "_addr"}, o_bus_addr, addr);
      check({tag, "_sel"},  32'(o_bus_sel), 32'(sel));
      if (chk_wd) check({tag, "_wdata"}, o_bus_wdata, wdata);
      if (i == lat - 1) begin
        i_bus_ack   = 1'b1;
        i_bus_rdata = rdata;
      end
      tick();
    end
    i_bus_ack = 1'b0;
    check({tag, "_drop"}, 32'(o_bus_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    tick();
    tick();
    check("rst_freeze", 32'(o_freeze), 32'd1);
    check("rst_req",    32'(o_bus_req), 32'd0);
    check("rst_instr",  o_instr, 32'h0000_0013);
    check("rst_valid",  32'(o_instr_valid), 32'd0);
    check("rst_rdata",  o_data_rdata, 32'd0);
    check("rst_commit", 32'(o_commit), 32'd0);
    check("rst_err",    32'(o_bus_err), 32'd0);
    check("rst_addr",   o_bus_addr, 32'd0);

    // Non-memory instruction: ack arrives 2 cycles after req rises
    rst = 1'b0;
    tick();                      // S_IDLE -> S_FETCH
    t0 = cyc;
    bus_xfer("f1", 3, 32'h0050_0093, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    check("f1_instr",  o_instr, 32'h0050_0093);
    check("f1_valid",  32'(o_instr_valid), 32'd1);
    check("f1_exfrz",  32'(o_freeze), 32'd1);
    check("f1_excmt",  32'(o_commit), 32'd0);
    tick();                      // S_COMMIT
    check("f1_freeze", 32'(o_freeze), 32'd0);
    check("f1_commit", 32'(o_commit), 32'd1);
    // req-rise cycle through commit cycle inclusive: 3 fetch + exec + commit
    check("f1_lat",    32'(cyc - t0 + 1), 32'd5);
    tick();                      // next S_FETCH
    check("f1_cmt_end", 32'(o_commit), 32'd0);
    check("f1_frz_end", 32'(o_freeze), 32'd1);
    check("f1_vld_end", 32'(o_instr_valid), 32'd0);

    // Load
    t0 = cyc;
    bus_xfer("f2", 1, 32'h0000_2083, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    i_data_read = 1'b1;
    i_data_addr = 32'h2000;
    i_data_sel  = 4'hF;
    tick();                      // S_DATA
    i_data_read = 1'b0;
    i_data_addr = 32'hFFFF_0000;
    i_data_sel  = 4'h1;
    bus_xfer("ld", 2, 32'hDEAD_BEEF, 1'b0, 32'h2000, 32'h0, 4'hF, 1'b0);
    check("ld_rdata",  o_data_rdata, 32'hDEAD_BEEF);
    check("ld_commit", 32'(o_commit), 32'd1);
    // 1 fetch + exec + 2 data + commit
    check("ld_lat",    32'(cyc - t0 + 1), 32'd5);
    tick();
    check("ld_one_cmt", 32'(o_commit), 32'd0);

    // Store with read and write both high
    bus_xfer("f3", 1, 32'h0011_2023, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    i_data_read  = 1'b1;
    i_data_write = 1'b1;
    i_data_addr  = 32'h3000;
    i_data_wdata = 32'h1234_5678;
    i_data_sel   = 4'b0011;
    tick();                      // S_DATA
    i_data_read  = 1'b0;
    i_data_write = 1'b0;
    i_data_addr  = 32'h0;
    i_data_wdata = 32'h0;
    i_data_sel   = 4'hF;
    bus_xfer("st", 3, 32'hFFFF_FFFF, 1'b1, 32'h3000, 32'h1234_5678, 4'b0011, 1'b1);
    check("st_rdata",  o_data_rdata, 32'hDEAD_BEEF);
    check("st_commit", 32'(o_commit), 32'd1);

    // Stray ack in S_COMMIT must not complete the next fetch
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'hBAD0_BAD0;
    tick();                      // S_FETCH
    i_bus_ack   = 1'b0;
    check("sp_instr1", o_instr, 32'h0011_2023);
    tick();
    check("sp_wait",   32'(o_bus_req), 32'd1);
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'h0000_0513;
    tick();                      // S_EXEC
    i_bus_ack   = 1'b0;
    check("sp_instr2", o_instr, 32'h0000_0513);
    // Stray ack in S_EXEC
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'hCAFE_F00D;
    tick();                      // S_COMMIT
    i_bus_ack   = 1'b0;
    check("sp_instr3", o_instr, 32'h0000_0513);
    check("sp_rdata",  o_data_rdata, 32'hDEAD_BEEF);
    check("sp_commit", 32'(o_commit), 32'd1);
    tick();                      // S_FETCH

    // Fetch timeout with ACK_TIMEOUT = 4
    for (int i = 0; i < 4; i++) begin
      check("to_req_hi", 32'(o_bus_req), 32'd1);
      tick();
    end
    check("to_req_lo", 32'(o_bus_req), 32'd0);
    check("to_instr",  o_instr, 32'h0000_0013);
    check("to_err",    32'(o_bus_err), 32'd1);
    check("to_valid",  32'(o_instr_valid), 32'd0);
    tick();
    check("to_commit", 32'(o_commit), 32'd1);
    tick();                      // S_FETCH
    check("to_sticky", 32'(o_bus_err), 32'd1);

    // Reset mid-S_DATA with an ack in the same cycle
    bus_xfer("f5", 1, 32'h0000_A103, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    i_data_read = 1'b1;
    i_data_addr = 32'h4000;
    tick();                      // S_DATA
    i_data_read = 1'b0;
    check("rs_req_hi", 32'(o_bus_req), 32'd1);
    tick();
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'h5555_5555;
    rst         = 1'b1;
    tick();
    i_bus_ack   = 1'b0;
    check("rs_req",    32'(o_bus_req), 32'd0);
    check("rs_freeze", 32'(o_freeze), 32'd1);
    check("rs_rdata",  o_data_rdata, 32'd0);
    check("rs_state",  32'(dut.state), 32'(t03_pkg::S_IDLE));
    check("rs_commit", 32'(o_commit), 32'd0);
    check("rs_err",    32'(o_bus_err), 32'd0);
    rst = 1'b0;
    tick();
    check("rs_commit2", 32'(o_commit), 32'd0);
    check("rs_refetch", 32'(o_bus_req), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
